// File: rtl/packet_filter_pkg.sv
// Shared types and register map for the frame generator and its packet-filter consumers.
`ifndef STUBBING_PASSTHROUGH
`define STUBBING_PASSTHROUGH 1'b1
`endif
`ifndef STUBBING_FUNCTIONAL
`define STUBBING_FUNCTIONAL 1'b0
`endif

package packet_filter_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} fgs_state_t;

  localparam int ETH_HDR_BYTES = 14;

  localparam logic [7:0] A_DST0   = 8'd0;
  localparam logic [7:0] A_SRC0   = 8'd6;
  localparam logic [7:0] A_LEN0   = 8'd12;
  localparam logic [7:0] A_LEN1   = 8'd13;
  localparam logic [7:0] A_TYPE0  = 8'd14;
  localparam logic [7:0] A_TYPE1  = 8'd15;
  localparam logic [7:0] A_IFG    = 8'd16;
  localparam logic [7:0] A_COUNT  = 8'd17;
  localparam logic [7:0] A_CTRL   = 8'd18;
  localparam logic [7:0] A_CONST  = 8'd19;
  localparam logic [7:0] A_CSUM0  = 8'd20;
  localparam logic [7:0] A_CSUM1  = 8'd21;
  localparam logic [7:0] A_CSUM2  = 8'd22;
  localparam logic [7:0] A_CSUM3  = 8'd23;
  localparam logic [7:0] A_STATUS = 8'd24;
  localparam logic [7:0] A_SENT   = 8'd25;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_MODE  = 2;

endpackage

// File: rtl/fgs_byte_packer.sv
// Builds one egress beat from the running byte index: header bytes, then payload pattern,
// with per-lane keep, frame-last flag and the sum of payload bytes carried by the beat.
module fgs_byte_packer import packet_filter_pkg::*; #(
  parameter int BPB = 2
) (
  input  logic [15:0]                   byte_idx,
  input  logic [15:0]                   total,
  input  logic [ETH_HDR_BYTES-1:0][7:0] hdr,
  input  logic                          mode,
  input  logic [7:0]                    const_byte,
  input  logic [7:0]                    frame_idx,
  output logic [BPB-1:0][7:0]           data,
  output logic [BPB-1:0]                keep,
  output logic                          last,
  output logic [15:0]                   pay_sum
);

  logic [BPB-1:0][7:0] pay_byte;
  logic [BPB-1:0]      is_pay;

  for (genvar k = 0; k < BPB; k++) begin : g_lane
    logic [15:0] idx;
    logic [7:0]  pidx;
    assign idx         = byte_idx + 16'(k);
    assign pidx        = idx[7:0] - 8'(ETH_HDR_BYTES);
    assign keep[k]     = idx < total;
    assign is_pay[k]   = keep[k] && (idx >= 16'(ETH_HDR_BYTES));
    assign pay_byte[k] = mode ? const_byte : frame_idx + pidx;
    assign data[k]     = !keep[k] ? 8'h00 : (is_pay[k] ? pay_byte[k] : hdr[idx[3:0]]);
  end

  assign last = ({1'b0, byte_idx} + 17'(BPB)) >= {1'b0, total};

  always_comb begin
    pay_sum = '0;
    for (int k = 0; k < BPB; k++)
      if (is_pay[k]) pay_sum = pay_sum + {8'h00, pay_byte[k]};
  end

endmodule

// File: rtl/frame_gen_stream.sv
// Ethernet frame generator: Avalon-MM register file, frame FSM and AXI-Stream egress,
// with a running payload checksum and busy/done status.
`ifndef STUBBING_PASSTHROUGH
`define STUBBING_PASSTHROUGH 1'b1
`endif

module frame_gen_stream import packet_filter_pkg::*; #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PAYLOAD = 1500,
  parameter bit STUBBING    = `STUBBING_PASSTHROUGH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              writedata,
  input  logic                    write,
  input  logic                    chipselect,
  input  logic [7:0]              address,
  input  logic                    read,
  output logic [7:0]              readdata,
  output logic [DATA_WIDTH-1:0]   egress_port_tdata,
  output logic [DATA_WIDTH/8-1:0] egress_port_tkeep,
  output logic                    egress_port_tlast,
  input  logic                    egress_port_tready,
  output logic                    egress_port_tvalid
);

  localparam int BPB = DATA_WIDTH / 8;

  fgs_state_t state, state_nx;

  logic [ETH_HDR_BYTES-1:0][7:0] hdr;
  logic [15:0] len_reg, pay_len, total, byte_idx;
  logic [7:0]  ifg, count, const_byte, frame_idx, frame_nx, gap_cnt;
  logic        mode, done, stop_pend;
  logic [31:0] csum;

  logic busy, active, hs, wr, rd, ctrl_wr, start_req, stop_req, stop_now;
  logic cnt_hit_now, cnt_hit_gap;
  logic ld_start, frame_end, gap_ld, set_done;

  logic [BPB-1:0][7:0] pk_data;
  logic [BPB-1:0]      pk_keep;
  logic                pk_last;
  logic [15:0]         pk_sum;

  assign busy      = state != IDLE;
  assign active    = (state == HEADER) || (state == PAYLOAD);
  assign hs        = egress_port_tvalid && egress_port_tready;
  assign wr        = chipselect && write;
  assign rd        = chipselect && read;
  assign ctrl_wr   = wr && (address == A_CTRL);
  assign start_req = ctrl_wr && writedata[CTRL_START] && !STUBBING;
  assign stop_req  = ctrl_wr && writedata[CTRL_STOP];
  assign stop_now  = stop_pend || stop_req;

  assign pay_len     = (len_reg > 16'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : len_reg;
  assign total       = pay_len + 16'(ETH_HDR_BYTES);
  assign frame_nx    = frame_idx + 8'd1;
  assign cnt_hit_now = (count != 8'd0) && (frame_nx == count);
  assign cnt_hit_gap = (count != 8'd0) && (frame_idx == count);

  fgs_byte_packer #(.BPB(BPB)) u_packer (
    .byte_idx  (byte_idx),
    .total     (total),
    .hdr       (hdr),
    .mode      (mode),
    .const_byte(const_byte),
    .frame_idx (frame_idx),
    .data      (pk_data),
    .keep      (pk_keep),
    .last      (pk_last),
    .pay_sum   (pk_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ld_start  = 1'b0;
    frame_end = 1'b0;
    gap_ld    = 1'b0;
    set_done  = 1'b0;
    case (state)
      IDLE: if (start_req) begin
        state_nx = HEADER;
        ld_start = 1'b1;
      end
      HEADER, PAYLOAD: if (hs) begin
        if (pk_last) begin
          frame_end = 1'b1;
          // a pending stop ends the run right at tlast, without waiting out the gap
          if (stop_now || (ifg == 8'd0 && cnt_hit_now)) begin
            state_nx = IDLE;
            set_done = 1'b1;
          end else if (ifg == 8'd0) begin
            state_nx = HEADER;
          end else begin
            state_nx = GAP;
            gap_ld   = 1'b1;
          end
        end else if (({1'b0, byte_idx} + 17'(BPB)) >= 17'(ETH_HDR_BYTES)) begin
          state_nx = PAYLOAD;
        end else begin
          state_nx = HEADER;
        end
      end
      GAP: if (gap_cnt >= ifg) begin
        if (stop_now || cnt_hit_gap) begin
          state_nx = IDLE;
          set_done = 1'b1;
        end else begin
          state_nx = HEADER;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx  <= '0;
      frame_idx <= '0;
      gap_cnt   <= '0;
      csum      <= '0;
      done      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (ld_start) begin
        byte_idx  <= '0;
        frame_idx <= '0;
        csum      <= '0;
        done      <= 1'b0;
        stop_pend <= 1'b0;
      end
      if (hs) begin
        csum     <= csum + 32'(pk_sum);
        byte_idx <= pk_last ? 16'd0 : byte_idx + 16'(BPB);
      end
      if (frame_end) frame_idx <= frame_nx;
      if (gap_ld)              gap_cnt <= 8'd1;
      else if (state == GAP)   gap_cnt <= gap_cnt + 8'd1;
      if (stop_req && busy)    stop_pend <= 1'b1;
      if (set_done) begin
        done      <= 1'b1;
        stop_pend <= 1'b0;
      end
    end
  end

  // config is frozen while a run is active so a stalled beat never changes under the sink
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr        <= '0;
      len_reg    <= '0;
      ifg        <= '0;
      count      <= '0;
      const_byte <= '0;
      mode       <= 1'b0;
    end else if (wr && !busy) begin
      if (address < 8'd12) hdr[address[3:0]] <= writedata;
      case (address)
        A_LEN0:  len_reg[7:0]  <= writedata;
        A_LEN1:  len_reg[15:8] <= writedata;
        A_TYPE0: hdr[12]       <= writedata;
        A_TYPE1: hdr[13]       <= writedata;
        A_IFG:   ifg           <= writedata;
        A_COUNT: count         <= writedata;
        A_CTRL:  mode          <= writedata[CTRL_MODE];
        A_CONST: const_byte    <= writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else if (rd) begin
      case (address)
        A_CSUM0:  readdata <= csum[7:0];
        A_CSUM1:  readdata <= csum[15:8];
        A_CSUM2:  readdata <= csum[23:16];
        A_CSUM3:  readdata <= csum[31:24];
        A_STATUS: readdata <= {6'b0, done, busy};
        A_SENT:   readdata <= frame_idx;
        default:  readdata <= '0;
      endcase
    end else readdata <= '0;
  end

  assign egress_port_tvalid = active && !STUBBING;
  assign egress_port_tdata  = egress_port_tvalid ? pk_data : '0;
  assign egress_port_tkeep  = egress_port_tvalid ? pk_keep : '0;
  assign egress_port_tlast  = egress_port_tvalid && pk_last;

endmodule

// File: tb/tb_frame_gen_stream.sv
// Scoreboard bench for frame_gen_stream at 16- and 32-bit egress widths.
module tb_frame_gen_stream;
  import packet_filter_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] writedata = '0, address = '0;
  logic write = 1'b0, read = 1'b0, cs16 = 1'b0, cs32 = 1'b0;
  logic [7:0] rd16, rd32;
  logic [15:0] td16; logic [1:0] tk16; logic tl16, tv16, tr16 = 1'b0;
  logic [31:0] td32; logic [3:0] tk32; logic tl32, tv32, tr32 = 1'b0;

  always #5 clk = ~clk;

  frame_gen_stream #(.DATA_WIDTH(16), .MAX_PAYLOAD(1500), .STUBBING(1'b0)) dut16 (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(cs16),
    .address(address), .read(read), .readdata(rd16),
    .egress_port_tdata(td16), .egress_port_tkeep(tk16), .egress_port_tlast(tl16),
    .egress_port_tready(tr16), .egress_port_tvalid(tv16));

  frame_gen_stream #(.DATA_WIDTH(32), .MAX_PAYLOAD(1500), .STUBBING(1'b0)) dut32 (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(cs32),
    .address(address), .read(read), .readdata(rd32),
    .egress_port_tdata(td32), .egress_port_tkeep(tk32), .egress_port_tlast(tl32),
    .egress_port_tready(tr32), .egress_port_tvalid(tv32));

  beat_t sb[$];
  int gaps[$];
  int checks = 0, errors = 0;
  logic [31:0] exp_csum;
  logic [7:0] mac [12];
  logic [7:0] ty [2];

  task automatic bus_write(input bit sel, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1; cs16 = !sel; cs32 = sel;
    @(posedge clk); #1;
    write = 1'b0; cs16 = 1'b0; cs32 = 1'b0;
  endtask

  task automatic bus_read(input bit sel, input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    address = a; read = 1'b1; cs16 = !sel; cs32 = sel;
    @(posedge clk); #1;
    read = 1'b0; cs16 = 1'b0; cs32 = 1'b0;
    d = sel ? rd32 : rd16;
  endtask

  task automatic read_csum(input bit sel, output logic [31:0] c);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_read(sel, 8'(A_CSUM0 + 8'(i)), b);
      c[8*i +: 8] = b;
    end
  endtask

  task automatic cfg(input bit sel, input logic [15:0] len, input logic [7:0] cnt,
                     input logic [7:0] ifg, input bit mode, input logic [7:0] cb);
    for (int i = 0; i < 12; i++) bus_write(sel, 8'(i), mac[i]);
    bus_write(sel, A_LEN0, len[7:0]);
    bus_write(sel, A_LEN1, len[15:8]);
    bus_write(sel, A_TYPE0, ty[0]);
    bus_write(sel, A_TYPE1, ty[1]);
    bus_write(sel, A_IFG, ifg);
    bus_write(sel, A_COUNT, cnt);
    bus_write(sel, A_CONST, cb);
    bus_write(sel, A_CTRL, {5'b0, mode, 2'b00});
  endtask

  task automatic start(input bit sel, input bit mode);
    bus_write(sel, A_CTRL, {5'b0, mode, 2'b01});
  endtask

  // reference model: serialise header + payload, then cut into beats
  task automatic push_frame(input int bpb, input int len, input bit mode,
                            input logic [7:0] cb, input logic [7:0] fidx);
    logic [7:0] b[$];
    beat_t e;
    for (int i = 0; i < 12; i++) b.push_back(mac[i]);
    b.push_back(ty[0]);
    b.push_back(ty[1]);
    for (int i = 0; i < len; i++) begin
      logic [7:0] p;
      p = mode ? cb : fidx + 8'(i);
      b.push_back(p);
      exp_csum = exp_csum + {24'h0, p};
    end
    for (int p = 0; p < b.size(); p += bpb) begin
      e = '0;
      for (int j = 0; j < bpb; j++)
        if (p + j < b.size()) begin
          e.data[8*j +: 8] = b[p + j];
          e.keep[j] = 1'b1;
        end
      e.last = (p + bpb) >= b.size();
      sb.push_back(e);
    end
  endtask

  // consume beats against the scoreboard; also checks stall stability and records gaps
  task automatic drain(input bit sel, input bit bp, input int budget);
    int cyc = 0, gcnt = 0, nbeat = 0;
    bit rdy, stall = 1'b0, in_gap = 1'b0, v, l;
    logic [31:0] d, hd; logic [3:0] k, hk; logic hl;
    beat_t e;
    gaps.delete();
    hd = '0; hk = '0; hl = 1'b0;
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      rdy = bp ? (cyc % 2 == 1) : 1'b1;
      if (sel) tr32 = rdy; else tr16 = rdy;
      v = sel ? tv32 : tv16;
      d = sel ? td32 : {16'h0, td16};
      k = sel ? tk32 : {2'b0, tk16};
      l = sel ? tl32 : tl16;
      if (stall) begin
        checks++;
        if (!v || d !== hd || k !== hk || l !== hl) begin
          errors++;
          $display("FAIL stall_hold beat %0d: got v=%b %h/%h/%b want v=1 %h/%h/%b", nbeat, v, d, k, l, hd, hk, hl);
        end
      end
      if (v && in_gap) begin gaps.push_back(gcnt); in_gap = 1'b0; end
      else if (!v && in_gap) gcnt++;
      stall = v && !rdy;
      hd = d; hk = k; hl = l;
      if (v && rdy) begin
        e = sb.pop_front();
        checks++;
        if (d !== e.data || k !== e.keep || l !== e.last) begin
          errors++;
          $display("FAIL beat %0d: got %h/%h/%b want %h/%h/%b", nbeat, d, k, l, e.data, e.keep, e.last);
        end
        nbeat++;
        if (l) begin in_gap = 1'b1; gcnt = 0; end
      end
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats left want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    tr16 = 1'b0; tr32 = 1'b0;
  endtask

  task automatic set_hdr;
    for (int i = 0; i < 6; i++) mac[i] = 8'(i + 1);
    for (int i = 0; i < 6; i++) mac[6 + i] = 8'(8'h0A + i);
    ty[0] = 8'h08; ty[1] = 8'h00;
  endtask

  task automatic test_reset;
    logic [7:0] r;
    int n = 0, cyc = 0;
    checks++;
    if (tv16 !== 1'b0 || td16 !== 16'h0 || rd16 !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tv=%b td=%h rd=%h want 0/0/0", tv16, td16, rd16);
    end
    @(negedge clk); reset = 1'b0;
    set_hdr();
    cfg(1'b0, 16'd5, 8'd1, 8'd0, 1'b0, 8'h00);
    tr16 = 1'b1;
    start(1'b0, 1'b0);
    while (n < 3 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (tv16) n++;
    end
    checks++;
    if (n < 3) begin errors++; $display("FAIL reset_prestart: got %0d beats want 3", n); end
    reset = 1'b1;
    #1;
    checks++;
    if (tv16 !== 1'b0 || tl16 !== 1'b0 || tk16 !== 2'b0 || td16 !== 16'h0) begin
      errors++;
      $display("FAIL reset_midframe: got tv=%b tl=%b tk=%b td=%h want all 0", tv16, tl16, tk16, td16);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; tr16 = 1'b0;
    bus_read(1'b0, A_STATUS, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", r); end
    bus_read(1'b0, 8'd0, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reset_reg0: got %h want 00", r); end
    bus_read(1'b0, A_SENT, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reset_sent: got %h want 00", r); end
  endtask

  task automatic check_done(input string nm, input bit sel, input logic [7:0] sent);
    logic [7:0] r; logic [31:0] c;
    repeat (8) @(posedge clk);
    read_csum(sel, c);
    checks++;
    if (c !== exp_csum) begin errors++; $display("FAIL %s_csum: got %h want %h", nm, c, exp_csum); end
    bus_read(sel, A_STATUS, r);
    checks++;
    if (r !== 8'h02) begin errors++; $display("FAIL %s_status: got %h want 02", nm, r); end
    bus_read(sel, A_SENT, r);
    checks++;
    if (r !== sent) begin errors++; $display("FAIL %s_sent: got %h want %h", nm, r, sent); end
  endtask

  task automatic test_basic;
    set_hdr();
    cfg(1'b0, 16'd5, 8'd1, 8'd0, 1'b0, 8'h00);
    exp_csum = '0;
    push_frame(2, 5, 1'b0, 8'h00, 8'h00);
    start(1'b0, 1'b0);
    drain(1'b0, 1'b0, 100);
    check_done("basic", 1'b0, 8'd1);
  endtask

  task automatic test_backpressure;
    exp_csum = '0;
    push_frame(2, 5, 1'b0, 8'h00, 8'h00);
    start(1'b0, 1'b0);
    drain(1'b0, 1'b1, 200);
    check_done("bp", 1'b0, 8'd1);
  endtask

  task automatic test_multi_frame;
    cfg(1'b0, 16'd0, 8'd3, 8'd4, 1'b0, 8'h00);
    exp_csum = '0;
    for (int f = 0; f < 3; f++) push_frame(2, 0, 1'b0, 8'h00, 8'(f));
    start(1'b0, 1'b0);
    drain(1'b0, 1'b0, 200);
    checks++;
    if (gaps.size() != 2) begin
      errors++; $display("FAIL multi_gap_count: got %0d want 2", gaps.size());
    end else
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (gaps[i] != 4) begin errors++; $display("FAIL multi_gap%0d: got %0d want 4", i, gaps[i]); end
      end
    check_done("multi", 1'b0, 8'd3);
  endtask

  task automatic test_width_straddle;
    set_hdr();
    cfg(1'b1, 16'd3, 8'd1, 8'd0, 1'b1, 8'hAA);
    exp_csum = '0;
    push_frame(4, 3, 1'b1, 8'hAA, 8'h00);
    start(1'b1, 1'b1);
    drain(1'b1, 1'b0, 100);
    check_done("width", 1'b1, 8'd1);
  endtask

  task automatic test_clamp_stop;
    int extra = 0;
    cfg(1'b0, 16'd2000, 8'd0, 8'd2, 1'b0, 8'h00);
    exp_csum = '0;
    push_frame(2, 1500, 1'b0, 8'h00, 8'h00);
    start(1'b0, 1'b0);
    fork
      drain(1'b0, 1'b0, 2000);
      begin
        repeat (100) @(posedge clk);
        bus_write(1'b0, A_CTRL, 8'h02);
      end
    join
    tr16 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tv16) extra++;
    end
    tr16 = 1'b0;
    checks++;
    if (extra != 0) begin errors++; $display("FAIL clamp_after_stop: got %0d valid cycles want 0", extra); end
    check_done("clamp", 1'b0, 8'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_multi_frame();
    test_width_straddle();
    test_clamp_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
